// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MIPS pipeline memory stage (package mips_pipe_pkg).
package mips_pipe_pkg;

    localparam int MIPS_DATA_W      = 32;
    localparam int MIPS_REG_W       = 5;
    localparam int MIPS_ACK_TIMEOUT = 15;
    localparam int TIMEOUT_CNT_W    = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // Counter value on the last ACCESS cycle before an unacknowledged access aborts.
    function automatic logic [TIMEOUT_CNT_W-1:0] timeout_last(input int timeout);
        return TIMEOUT_CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W
);

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_wb_stage_dmem_handshake_fsm.sv
// Data-memory handshake controller: IDLE/ACCESS FSM, ack timeout counter and upstream stall.
// MEM_ALIGN_CHECK_EN adds a misaligned-access reject path with a one-cycle align_err pulse.
module dmem_handshake_fsm
    import mips_pipe_pkg::*;
#(
    parameter int ACK_TIMEOUT = MIPS_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_rd,
    input  logic i_mem_wr,
    input  logic i_ack,
`ifdef MEM_ALIGN_CHECK_EN
    input  logic i_misaligned,
    output logic o_align_err,
`endif
    output logic o_req,
    output logic o_we,
    output logic o_stall,
    output logic o_bus_err,
    output logic o_start,
    output logic o_wb_load,
    output logic o_use_rdata
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_WAIT = timeout_last(ACK_TIMEOUT);

    mem_state_t               r_state;
    mem_state_t               w_next_state;
    logic [TIMEOUT_CNT_W-1:0] r_count;
    logic [TIMEOUT_CNT_W-1:0] w_next_count;
    logic                     r_req;
    logic                     w_next_req;
    logic                     r_we;
    logic                     w_next_we;
    logic                     r_bus_err;
    logic                     w_next_bus_err;
    logic                     w_stall;
    logic                     w_mem_op;
`ifdef MEM_ALIGN_CHECK_EN
    logic                     r_align_err;
    logic                     w_next_align_err;
`endif

    assign w_mem_op = i_mem_rd | i_mem_wr;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            r_req     <= w_next_req;
            r_we      <= w_next_we;
            r_bus_err <= w_next_bus_err;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= w_next_align_err;
`endif
        end
    end

    // An ack on the final wait cycle completes the access instead of aborting it.
    always_comb begin
        w_next_state   = r_state;
        w_next_count   = r_count;
        w_next_req     = r_req;
        w_next_we      = r_we;
        w_next_bus_err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        w_next_align_err = 1'b0;
`endif
        w_stall        = 1'b0;
        o_start        = 1'b0;
        o_wb_load      = 1'b0;
        o_use_rdata    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_mem_op) begin
                    o_wb_load = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                end else if (i_misaligned) begin
                    w_next_align_err = 1'b1;
`endif
                end else begin
                    w_stall      = 1'b1;
                    o_start      = 1'b1;
                    w_next_state = ACCESS;
                    w_next_count = '0;
                    w_next_req   = 1'b1;
                    w_next_we    = i_mem_wr;
                end
            end
            ACCESS: begin
                if (i_ack) begin
                    o_wb_load    = 1'b1;
                    o_use_rdata  = 1'b1;
                    w_next_state = IDLE;
                    w_next_req   = 1'b0;
                    w_next_we    = 1'b0;
                end else if (r_count == LAST_WAIT) begin
                    w_next_bus_err = 1'b1;
                    w_next_state   = IDLE;
                    w_next_req     = 1'b0;
                    w_next_we      = 1'b0;
                end else begin
                    w_stall      = 1'b1;
                    w_next_count = r_count + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_req     = r_req;
    assign o_we      = r_we;
    assign o_bus_err = r_bus_err;
    assign o_stall   = w_stall & ~rst;
`ifdef MEM_ALIGN_CHECK_EN
    assign o_align_err = r_align_err;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: runs the data-memory handshake and registers write-back data.
// MEM_ALIGN_CHECK_EN rejects misaligned loads/stores and adds the align_err output.
module mem_wb_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W      = MIPS_DATA_W,
    parameter int REG_W       = MIPS_REG_W,
    parameter int ACK_TIMEOUT = MIPS_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [DATA_W-1:0] dato_b_in,
    input  logic              mux_flag_2_in,
    input  logic              mux_flag_3_in,
    input  logic              mem_rd_in,
    input  logic              mem_wr_in,
    input  logic              banco_wr_in,
    mem_wb_stage_if.master    dmem,
    output logic              stall,
    output logic              bus_err,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              align_err,
`endif
    output logic              wb_we
);

    logic              w_start;
    logic              w_wb_load;
    logic              w_use_rdata;
    logic              w_req;
    logic              w_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_wb_reg;
    logic              r_wb_we;
`ifdef MEM_ALIGN_CHECK_EN
    logic              w_misaligned;

    assign w_misaligned = |alu_in[1:0];
`endif

    dmem_handshake_fsm #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_mem_rd    (mem_rd_in),
        .i_mem_wr    (mem_wr_in),
        .i_ack       (dmem.dmem_ack),
`ifdef MEM_ALIGN_CHECK_EN
        .i_misaligned(w_misaligned),
        .o_align_err (align_err),
`endif
        .o_req       (w_req),
        .o_we        (w_we),
        .o_stall     (stall),
        .o_bus_err   (bus_err),
        .o_start     (w_start),
        .o_wb_load   (w_wb_load),
        .o_use_rdata (w_use_rdata)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_addr  <= alu_in;
            r_wdata <= dato_b_in;
        end
    end

    // Edges that neither pass through nor complete an access leave a bubble (wb_we low).
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_wb_data <= '0;
            r_wb_reg  <= '0;
            r_wb_we   <= 1'b0;
        end else if (w_wb_load) begin
            r_wb_data <= (w_use_rdata && mux_flag_3_in) ? dmem.dmem_rdata : alu_in;
            r_wb_reg  <= mux_flag_2_in ? rd_in : rt_in;
            r_wb_we   <= banco_wr_in;
        end else begin
            r_wb_we   <= 1'b0;
        end
    end

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign wb_data         = r_wb_data;
    assign wb_reg          = r_wb_reg;
    assign wb_we           = r_wb_we;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases, reset mid-access, then random
// instructions checked against a transaction-level model. MEM_ALIGN_CHECK_EN adds an align case.
module tb_mem_wb_stage;
    import mips_pipe_pkg::*;

    localparam int DW          = 32;
    localparam int RW          = 5;
    localparam int TIMEOUT     = MIPS_ACK_TIMEOUT;
    localparam int CYCLE_BOUND = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_in;
    logic [RW-1:0] rd_in;
    logic [RW-1:0] rt_in;
    logic [DW-1:0] dato_b_in;
    logic          mux_flag_2_in;
    logic          mux_flag_3_in;
    logic          mem_rd_in;
    logic          mem_wr_in;
    logic          banco_wr_in;
    logic          stall;
    logic          bus_err;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_reg;
    logic          wb_we;
`ifdef MEM_ALIGN_CHECK_EN
    logic          align_err;
`endif

    mem_wb_stage_if #(.DATA_W(DW)) dmemBus ();

    mem_wb_stage #(
        .DATA_W      (DW),
        .REG_W       (RW),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_in        (alu_in),
        .rd_in         (rd_in),
        .rt_in         (rt_in),
        .dato_b_in     (dato_b_in),
        .mux_flag_2_in (mux_flag_2_in),
        .mux_flag_3_in (mux_flag_3_in),
        .mem_rd_in     (mem_rd_in),
        .mem_wr_in     (mem_wr_in),
        .banco_wr_in   (banco_wr_in),
        .dmem          (dmemBus),
        .stall         (stall),
        .bus_err       (bus_err),
        .wb_data       (wb_data),
        .wb_reg        (wb_reg),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err     (align_err),
`endif
        .wb_we         (wb_we)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] modelWbData;
    logic [RW-1:0] modelWbReg;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Runs one instruction from its first MEM cycle until the edge it retires on; the
    // bench plays data memory, acking after waitCycles ACCESS cycles (never if too long).
    task automatic applyStimulus(input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                                 input logic [RW-1:0] rt, input logic [DW-1:0] storeData,
                                 input logic mux2, input logic mux3, input logic memRd,
                                 input logic memWr, input logic bancoWr,
                                 input logic [DW-1:0] loadData, input int waitCycles);
        bit isMem;
        bit timedOut;
        bit done;
        bit lastCycle;
        int accessCycles;
        int expStall;
        int stallSeen;
        int reqSeen;
        logic expWe;

        isMem        = memRd | memWr;
        timedOut     = isMem && (waitCycles >= TIMEOUT);
        accessCycles = !isMem ? 0 : (timedOut ? TIMEOUT : waitCycles + 1);
        expStall     = !isMem ? 0 : 1 + (timedOut ? TIMEOUT - 1 : waitCycles);
        expWe        = timedOut ? 1'b0 : bancoWr;
        if (!timedOut) begin
            modelWbData = (isMem && mux3) ? loadData : alu;
            modelWbReg  = mux2 ? rd : rt;
        end

        alu_in        = alu;
        rd_in         = rd;
        rt_in         = rt;
        dato_b_in     = storeData;
        mux_flag_2_in = mux2;
        mux_flag_3_in = mux3;
        mem_rd_in     = memRd;
        mem_wr_in     = memWr;
        banco_wr_in   = bancoWr;

        stallSeen = 0;
        reqSeen   = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < CYCLE_BOUND && !done; cyc++) begin
            if (dmemBus.dmem_req) begin
                if (reqSeen == 0) begin
                    checkOutput("dmemAddr", dmemBus.dmem_addr, alu);
                    checkOutput("dmemWdata", dmemBus.dmem_wdata, storeData);
                    checkOutput("dmemWe", 32'(dmemBus.dmem_we), 32'(memWr));
                end
                dmemBus.dmem_ack   = (reqSeen == waitCycles);
                dmemBus.dmem_rdata = loadData;
                reqSeen++;
            end else begin
                dmemBus.dmem_ack   = ($urandom_range(0, 3) == 0);
                dmemBus.dmem_rdata = $urandom;
            end
            #1;
            if (stall) stallSeen++;
            lastCycle = !stall;
            @(negedge clk);
            #1;
            if (lastCycle) begin
                checkOutput("wbWe", 32'(wb_we), 32'(expWe));
                checkOutput("wbData", wb_data, modelWbData);
                checkOutput("wbReg", 32'(wb_reg), 32'(modelWbReg));
                checkOutput("busErr", 32'(bus_err), 32'(timedOut));
                checkOutput("dmemReqDone", 32'(dmemBus.dmem_req), 32'd0);
                checkOutput("dmemWeDone", 32'(dmemBus.dmem_we), 32'd0);
                done = 1'b1;
            end else begin
                checkOutput("wbWeStalled", 32'(wb_we), 32'd0);
                checkOutput("busErrStalled", 32'(bus_err), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("cycleBound", 32'd0, 32'd1);
        checkOutput("stallCycles", 32'(stallSeen), 32'(expStall));
        checkOutput("reqCycles", 32'(reqSeen), 32'(accessCycles));
        dmemBus.dmem_ack = 1'b0;
    endtask

    task automatic applyRandomInstr();
        logic [DW-1:0] alu;
        logic [DW-1:0] storeData;
        logic [DW-1:0] loadData;
        logic [RW-1:0] rd;
        logic [RW-1:0] rt;
        logic          mux2;
        logic          mux3;
        logic          memRd;
        logic          memWr;
        logic          bancoWr;
        int            kind;
        int            waitCycles;

        alu = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
        alu[1:0] = 2'b00;
`endif
        storeData  = $urandom;
        loadData   = $urandom;
        rd         = RW'($urandom);
        rt         = RW'($urandom);
        mux2       = 1'($urandom);
        mux3       = 1'($urandom);
        bancoWr    = 1'($urandom);
        kind       = int'($urandom_range(0, 3));
        memWr      = (kind == 3);
        memRd      = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
        waitCycles = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 17))
                                                 : int'($urandom_range(0, 4));
        applyStimulus(alu, rd, rt, storeData, mux2, mux3, memRd, memWr, bancoWr,
                      loadData, waitCycles);
    endtask

    // Reset lands two ACCESS cycles into an unanswered load; a late ack must do nothing.
    task automatic applyResetMidAccess();
        alu_in        = 32'h0000_0100;
        rd_in         = 5'd12;
        rt_in         = 5'd3;
        mux_flag_2_in = 1'b1;
        mux_flag_3_in = 1'b1;
        mem_rd_in     = 1'b1;
        mem_wr_in     = 1'b0;
        banco_wr_in   = 1'b1;
        dmemBus.dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("preResetReq", 32'(dmemBus.dmem_req), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstReq", 32'(dmemBus.dmem_req), 32'd0);
        checkOutput("rstStall", 32'(stall), 32'd0);
        checkOutput("rstWbData", wb_data, 32'd0);
        checkOutput("rstWbReg", 32'(wb_reg), 32'd0);
        checkOutput("rstWbWe", 32'(wb_we), 32'd0);
        checkOutput("rstAddr", dmemBus.dmem_addr, 32'd0);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        alu_in        = '0;
        rd_in         = '0;
        rt_in         = '0;
        mux_flag_2_in = 1'b0;
        mux_flag_3_in = 1'b1;
        mem_rd_in     = 1'b0;
        banco_wr_in   = 1'b0;
        dmemBus.dmem_ack   = 1'b1;
        dmemBus.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("lateAckStall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("lateAckReq", 32'(dmemBus.dmem_req), 32'd0);
        checkOutput("lateAckData", wb_data, 32'd0);
        checkOutput("lateAckBusErr", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        dmemBus.dmem_ack = 1'b0;
        modelWbData = '0;
        modelWbReg  = '0;
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic applyMisalignedLoad();
        alu_in        = 32'h0000_0042;
        mem_rd_in     = 1'b1;
        mem_wr_in     = 1'b0;
        banco_wr_in   = 1'b1;
        #1;
        checkOutput("alignStall", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("alignReq", 32'(dmemBus.dmem_req), 32'd0);
        checkOutput("alignErr", 32'(align_err), 32'd1);
        checkOutput("alignWbWe", 32'(wb_we), 32'd0);
        @(posedge clk);
        #1;
        mem_rd_in   = 1'b0;
        banco_wr_in = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("alignErrPulse", 32'(align_err), 32'd0);
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst                = 1'b1;
        alu_in             = '0;
        rd_in              = '0;
        rt_in              = '0;
        dato_b_in          = '0;
        mux_flag_2_in      = 1'b0;
        mux_flag_3_in      = 1'b0;
        mem_rd_in          = 1'b0;
        mem_wr_in          = 1'b0;
        banco_wr_in        = 1'b0;
        dmemBus.dmem_ack   = 1'b0;
        dmemBus.dmem_rdata = '0;
        modelWbData        = '0;
        modelWbReg         = '0;
        #2;
        checkOutput("resetWbData", wb_data, 32'd0);
        checkOutput("resetWbReg", 32'(wb_reg), 32'd0);
        checkOutput("resetWbWe", 32'(wb_we), 32'd0);
        checkOutput("resetReq", 32'(dmemBus.dmem_req), 32'd0);
        checkOutput("resetWe", 32'(dmemBus.dmem_we), 32'd0);
        checkOutput("resetAddr", dmemBus.dmem_addr, 32'd0);
        checkOutput("resetWdata", dmemBus.dmem_wdata, 32'd0);
        checkOutput("resetBusErr", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(32'h0000_0010, 5'd0, 5'd8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      32'h0, 0);
        applyStimulus(32'h0000_0040, 5'd5, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                      32'hDEAD_BEEF, 3);
        applyStimulus(32'h0000_0080, 5'd0, 5'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1,
                      1'b0, 32'h0, 0);
        applyStimulus(32'h0000_00C0, 5'd7, 5'd9, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                      32'h0000_CAFE, 20);
        applyStimulus(32'h0000_00C4, 5'd10, 5'd11, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                      32'h5A5A_0F0F, TIMEOUT - 1);
        applyStimulus(32'h0000_00C8, 5'd13, 5'd14, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b1, 1'b1,
                      1'b1, 32'h0, 1);

        applyResetMidAccess();

        for (int n = 0; n < 60; n++) begin
            applyRandomInstr();
        end

`ifdef MEM_ALIGN_CHECK_EN
        applyMisalignedLoad();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
